text_cursor_engine: RTL and testbench

- Parametrised successor to the fixed-size edit path: converts a stream of ASCII keystrokes into cell-write requests for the character memory controller.
- Tracks the cursor over a selectable small- or large-glyph grid.
- Handles wrap-around, backspace, newline, full-screen clear and grid-mode changes.
- Sits between keyboard_in (upstream, ready/valid) and memory_controller (downstream, req/ack). Also drives the cursor highlight outputs.

---
 rtl/tbuff_pkg.sv | 28 ++
 rtl/grid_stepper.sv | 45 ++++
 rtl/text_cursor_engine.sv | 210 +++++++++++++++++++++
 tb/tb_text_cursor_engine.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tbuff_pkg.sv
// Shared definitions for the text cursor engine: keystroke codes, FSM encoding
// and default grid dimensions.
package tbuff_pkg;

    localparam logic [7:0] ASC_BS    = 8'h08;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_ESC   = 8'h1B;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] PRINT_MIN = 8'h20;
    localparam logic [7:0] PRINT_MAX = 8'h7E;

    localparam int COLS_S_DEF = 80;
    localparam int ROWS_S_DEF = 60;
    localparam int COLS_L_DEF = 40;
    localparam int ROWS_L_DEF = 30;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    function automatic logic is_printable(input logic [7:0] code);
        return (code >= PRINT_MIN) && (code <= PRINT_MAX);
    endfunction

endpackage

// File: rtl/grid_stepper.sv
// Combinational cell stepping over a cols x rows grid: next cell (row-major
// with wrap), previous cell, and the row below for newline.
module grid_stepper #(
    parameter int XW = 7,
    parameter int YW = 6
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [XW:0]   cols,
    input  logic [YW:0]   rows,
    output logic [XW-1:0] next_x,
    output logic [YW-1:0] next_y,
    output logic [XW-1:0] prev_x,
    output logic [YW-1:0] prev_y,
    output logic [YW-1:0] nl_y,
    output logic          at_last,
    output logic          at_origin
);

    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [XW:0]   XC_ONE = (XW+1)'(1);
    localparam logic [YW:0]   YC_ONE = (YW+1)'(1);

    logic [XW-1:0] last_x;
    logic [YW-1:0] last_y;
    logic          at_last_col;
    logic          at_last_row;

    assign last_x      = XW'(cols - XC_ONE);
    assign last_y      = YW'(rows - YC_ONE);
    assign at_last_col = (x == last_x);
    assign at_last_row = (y == last_y);
    assign at_last     = at_last_col && at_last_row;
    assign at_origin   = (x == '0) && (y == '0);

    assign nl_y   = at_last_row ? '0 : y + Y_ONE;
    assign next_x = at_last_col ? '0 : x + X_ONE;
    assign next_y = at_last_col ? nl_y : y;

    // Only meaningful away from the origin; the caller treats (0,0) as a no-op.
    assign prev_x = (x == '0) ? last_x : x - X_ONE;
    assign prev_y = (x == '0) ? y - Y_ONE : y;

endmodule

// File: rtl/text_cursor_engine.sv
// Converts an ASCII keystroke stream into cell-write requests and tracks the
// cursor over a small- or large-glyph grid.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a keystroke or a grid-mode change
// ST_WRITE | one cell write outstanding (printable or backspace blank)
// ST_CLEAR | sweeping the whole active grid with blanks, colour 0
module text_cursor_engine
    import tbuff_pkg::*;
#(
    parameter int COLS_S = COLS_S_DEF,
    parameter int ROWS_S = ROWS_S_DEF,
    parameter int COLS_L = COLS_L_DEF,
    parameter int ROWS_L = ROWS_L_DEF,
    parameter int XW     = 7,
    parameter int YW     = 6,
    parameter int CW     = 3
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          sL,
    input  logic          key_valid,
    input  logic [7:0]    key_ascii,
    output logic          key_ready,
    input  logic [CW-1:0] colour,
    output logic          wr_req,
    input  logic          wr_ack,
    output logic [XW-1:0] wr_x,
    output logic [YW-1:0] wr_y,
    output logic [7:0]    wr_ascii,
    output logic [CW-1:0] wr_colour,
    output logic [XW-1:0] cur_x,
    output logic [YW-1:0] cur_y,
    output logic          cur_en,
    output logic          busy
);

    localparam logic [XW:0] COLS_S_W = (XW+1)'(COLS_S);
    localparam logic [XW:0] COLS_L_W = (XW+1)'(COLS_L);
    localparam logic [YW:0] ROWS_S_W = (YW+1)'(ROWS_S);
    localparam logic [YW:0] ROWS_L_W = (YW+1)'(ROWS_L);

    state_t        state, state_d;
    logic          sl_q, sl_q_d;
    logic          bs_q, bs_d;
    logic [XW-1:0] cur_x_d, wr_x_d;
    logic [YW-1:0] cur_y_d, wr_y_d;
    logic          wr_req_d;
    logic [7:0]    wr_ascii_d;
    logic [CW-1:0] wr_colour_d;
    logic          mode_chg;
    logic          go_clear;

    logic [XW:0]   cols_act;
    logic [YW:0]   rows_act;
    logic [XW-1:0] step_x, next_x, prev_x;
    logic [YW-1:0] step_y, next_y, prev_y, nl_y;
    logic          at_last, at_origin;

    assign cols_act = sl_q ? COLS_L_W : COLS_S_W;
    assign rows_act = sl_q ? ROWS_L_W : ROWS_S_W;

    // The sweep walks the write address; everything else steps the cursor.
    assign step_x = (state == ST_CLEAR) ? wr_x : cur_x;
    assign step_y = (state == ST_CLEAR) ? wr_y : cur_y;

    grid_stepper #(
        .XW(XW),
        .YW(YW)
    ) u_stepper (
        .x        (step_x),
        .y        (step_y),
        .cols     (cols_act),
        .rows     (rows_act),
        .next_x   (next_x),
        .next_y   (next_y),
        .prev_x   (prev_x),
        .prev_y   (prev_y),
        .nl_y     (nl_y),
        .at_last  (at_last),
        .at_origin(at_origin)
    );

    assign mode_chg  = (sL != sl_q);
    assign key_ready = (state == ST_IDLE) && !mode_chg;
    assign cur_en    = (state != ST_CLEAR);
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_d     = state;
        sl_q_d      = sl_q;
        bs_d        = bs_q;
        cur_x_d     = cur_x;
        cur_y_d     = cur_y;
        wr_req_d    = wr_req;
        wr_x_d      = wr_x;
        wr_y_d      = wr_y;
        wr_ascii_d  = wr_ascii;
        wr_colour_d = wr_colour;
        go_clear    = 1'b0;

        case (state)
            ST_IDLE: begin
                sl_q_d = sL;
                if (mode_chg) begin
                    go_clear = 1'b1;
                end else if (key_valid) begin
                    if (is_printable(key_ascii)) begin
                        wr_req_d    = 1'b1;
                        wr_x_d      = cur_x;
                        wr_y_d      = cur_y;
                        wr_ascii_d  = key_ascii;
                        wr_colour_d = colour;
                        bs_d        = 1'b0;
                        state_d     = ST_WRITE;
                    end else begin
                        case (key_ascii)
                            ASC_BS: begin
                                if (!at_origin) begin
                                    cur_x_d     = prev_x;
                                    cur_y_d     = prev_y;
                                    wr_req_d    = 1'b1;
                                    wr_x_d      = prev_x;
                                    wr_y_d      = prev_y;
                                    wr_ascii_d  = ASC_SPACE;
                                    wr_colour_d = colour;
                                    bs_d        = 1'b1;
                                    state_d     = ST_WRITE;
                                end
                            end
                            ASC_CR, ASC_LF: begin
                                cur_x_d = '0;
                                cur_y_d = nl_y;
                            end
                            ASC_ESC: go_clear = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end

            ST_WRITE: begin
                if (wr_ack) begin
                    wr_req_d = 1'b0;
                    state_d  = ST_IDLE;
                    if (!bs_q) begin
                        cur_x_d = next_x;
                        cur_y_d = next_y;
                    end
                end
            end

            ST_CLEAR: begin
                if (wr_ack) begin
                    if (at_last) begin
                        wr_req_d = 1'b0;
                        cur_x_d  = '0;
                        cur_y_d  = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        wr_x_d = next_x;
                        wr_y_d = next_y;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Both ESC and a grid-mode change home the cursor and start the sweep.
        if (go_clear) begin
            cur_x_d     = '0;
            cur_y_d     = '0;
            wr_req_d    = 1'b1;
            wr_x_d      = '0;
            wr_y_d      = '0;
            wr_ascii_d  = ASC_SPACE;
            wr_colour_d = '0;
            state_d     = ST_CLEAR;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            sl_q      <= 1'b0;
            bs_q      <= 1'b0;
            cur_x     <= '0;
            cur_y     <= '0;
            wr_req    <= 1'b0;
            wr_x      <= '0;
            wr_y      <= '0;
            wr_ascii  <= '0;
            wr_colour <= '0;
        end else begin
            state     <= state_d;
            sl_q      <= sl_q_d;
            bs_q      <= bs_d;
            cur_x     <= cur_x_d;
            cur_y     <= cur_y_d;
            wr_req    <= wr_req_d;
            wr_x      <= wr_x_d;
            wr_y      <= wr_y_d;
            wr_ascii  <= wr_ascii_d;
            wr_colour <= wr_colour_d;
        end
    end

endmodule

// File: tb/tb_text_cursor_engine.sv
// Self-checking bench for text_cursor_engine: directed scenarios plus random
// keystrokes compared against a linear-position cursor model.
module tb_text_cursor_engine;

    localparam int COLS_S = 80;
    localparam int ROWS_S = 60;
    localparam int COLS_L = 40;
    localparam int ROWS_L = 30;
    localparam int XW     = 7;
    localparam int YW     = 6;
    localparam int CW     = 3;

    typedef struct {
        int x;
        int y;
        int a;
        int c;
        int held;
        bit stable;
    } wr_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          sL = 1'b0;
    logic          key_valid = 1'b0;
    logic [7:0]    key_ascii = 8'h00;
    logic          key_ready;
    logic [CW-1:0] colour = '0;
    logic          wr_req;
    logic          wr_ack = 1'b0;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    logic [7:0]    wr_ascii;
    logic [CW-1:0] wr_colour;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic          cur_en;
    logic          busy;

    int compared   = 0;
    int mismatched = 0;

    int  m_x = 0, m_y = 0, m_cols = COLS_S, m_rows = ROWS_S;
    wr_t wlog[$];
    int  ack_delay  = 0;
    int  req_cycles = 0;
    int  fx, fy, fa, fc;
    bit  unstable = 0;

    text_cursor_engine #(
        .COLS_S(COLS_S), .ROWS_S(ROWS_S), .COLS_L(COLS_L), .ROWS_L(ROWS_L),
        .XW(XW), .YW(YW), .CW(CW)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .sL       (sL),
        .key_valid(key_valid),
        .key_ascii(key_ascii),
        .key_ready(key_ready),
        .colour   (colour),
        .wr_req   (wr_req),
        .wr_ack   (wr_ack),
        .wr_x     (wr_x),
        .wr_y     (wr_y),
        .wr_ascii (wr_ascii),
        .wr_colour(wr_colour),
        .cur_x    (cur_x),
        .cur_y    (cur_y),
        .cur_en   (cur_en),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Memory-side responder: ack after ack_delay cycles of request.
    always @(negedge clk) wr_ack = wr_req && (req_cycles >= ack_delay);

    always @(posedge clk) begin
        if (!resetn) begin
            req_cycles = 0;
            unstable   = 0;
        end else if (wr_req) begin
            if (req_cycles == 0) begin
                fx = int'(wr_x); fy = int'(wr_y); fa = int'(wr_ascii); fc = int'(wr_colour);
            end else if (fx != int'(wr_x) || fy != int'(wr_y) || fa != int'(wr_ascii) || fc != int'(wr_colour)) begin
                unstable = 1;
            end
            if (wr_ack) begin
                wlog.push_back('{fx, fy, fa, fc, req_cycles + 1, !unstable});
                req_cycles = 0;
                unstable   = 0;
            end else begin
                req_cycles++;
            end
        end
    end

    function automatic void model_key(input logic [7:0] k, input int col, output bit exp_wr, output wr_t ew);
        int p;
        exp_wr = 0;
        ew = '{-1, -1, -1, -1, 0, 0};
        p = m_y * m_cols + m_x;
        if (k >= 8'h20 && k <= 8'h7E) begin
            exp_wr = 1;
            ew = '{m_x, m_y, int'(k), col, 0, 1};
            p = (p + 1) % (m_cols * m_rows);
            m_x = p % m_cols;
            m_y = p / m_cols;
        end else if (k == 8'h08) begin
            if (p > 0) begin
                p = p - 1;
                m_x = p % m_cols;
                m_y = p / m_cols;
                exp_wr = 1;
                ew = '{m_x, m_y, 32'h20, col, 0, 1};
            end
        end else if (k == 8'h0D || k == 8'h0A) begin
            m_x = 0;
            m_y = (m_y + 1) % m_rows;
        end
    endfunction

    task automatic apply_reset();
        key_valid = 0;
        key_ascii = 8'h00;
        sL = 0;
        resetn = 0;
        repeat (3) @(negedge clk);
        resetn = 1;
        wlog.delete();
        m_x = 0; m_y = 0; m_cols = COLS_S; m_rows = ROWS_S;
        @(negedge clk);
    endtask

    task automatic send_key(input logic [7:0] k);
        bit ok, acc;
        ok = 0;
        key_valid = 1;
        key_ascii = k;
        for (int i = 0; i < 20000 && !ok; i++) begin
            acc = key_ready;
            @(posedge clk);
            if (acc) ok = 1;
            @(negedge clk);
        end
        key_valid = 0;
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL key_accept_timeout key=%02h accepted=0 required=1", k);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20000 && busy; i++) @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_timeout busy=%b required=0", busy);
        end
    endtask

    task automatic do_key(input logic [7:0] k, input int dly, output int n_new, output wr_t got,
                          output bit exp_wr, output wr_t ew);
        int n0;
        colour    = CW'($urandom);
        ack_delay = dly;
        n0 = wlog.size();
        model_key(k, int'(colour), exp_wr, ew);
        send_key(k);
        wait_idle();
        n_new = wlog.size() - n0;
        got = '{-1, -1, -1, -1, 0, 0};
        if (n_new > 0) got = wlog[wlog.size() - 1];
    endtask

    task automatic test_reset();
        apply_reset();
        compared++;
        if ({wr_req, key_ready, cur_en, busy} !== 4'b0110) begin
            mismatched++;
            $display("FAIL reset_flags req/rdy/en/busy=%b required=0110", {wr_req, key_ready, cur_en, busy});
        end
        compared++;
        if (cur_x !== '0 || cur_y !== '0) begin
            mismatched++;
            $display("FAIL reset_cursor got=(%0d,%0d) required=(0,0)", cur_x, cur_y);
        end
        compared++;
        if (wr_x !== '0 || wr_y !== '0 || wr_ascii !== '0 || wr_colour !== '0) begin
            mismatched++;
            $display("FAIL reset_wrbus got=(%0d,%0d,%02h,%0d) required=(0,0,00,0)", wr_x, wr_y, wr_ascii, wr_colour);
        end
    endtask

    task automatic test_first_key();
        int n0;
        wr_t e;
        ack_delay = 0;
        colour = 3'd5;
        n0 = wlog.size();
        key_valid = 1;
        key_ascii = 8'h41;
        @(posedge clk);
        @(negedge clk);
        key_valid = 0;
        compared++;
        if (wr_req !== 1'b1 || key_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL first_key_n1 req=%b rdy=%b required req=1 rdy=0", wr_req, key_ready);
        end
        compared++;
        if (wr_x !== 7'd0 || wr_y !== 6'd0 || wr_ascii !== 8'h41 || wr_colour !== 3'd5) begin
            mismatched++;
            $display("FAIL first_key_bus got=(%0d,%0d,%02h,%0d) required=(0,0,41,5)", wr_x, wr_y, wr_ascii, wr_colour);
        end
        @(negedge clk);
        compared++;
        if (key_ready !== 1'b1 || wr_req !== 1'b0) begin
            mismatched++;
            $display("FAIL first_key_n2 rdy=%b req=%b required rdy=1 req=0", key_ready, wr_req);
        end
        compared++;
        if (cur_x !== 7'd1 || cur_y !== 6'd0) begin
            mismatched++;
            $display("FAIL first_key_cursor got=(%0d,%0d) required=(1,0)", cur_x, cur_y);
        end
        compared++;
        if (wlog.size() - n0 != 1) begin
            mismatched++;
            $display("FAIL first_key_count got=%0d required=1", wlog.size() - n0);
        end else begin
            e = wlog[n0];
            if (e.x != 0 || e.y != 0 || e.a != 'h41 || e.c != 5 || e.held != 1) begin
                mismatched++;
                $display("FAIL first_key_entry got=(%0d,%0d,%02h,%0d,held %0d) required=(0,0,41,5,held 1)",
                         e.x, e.y, e.a, e.c, e.held);
            end
        end
        m_x = 1;
        m_y = 0;
    endtask

    task automatic test_wrap();
        int n; wr_t g, ew; bit ex;
        apply_reset();
        for (int i = 0; i < 59; i++) do_key(8'h0A, 0, n, g, ex, ew);
        for (int i = 0; i < 79; i++) do_key(8'($urandom_range(32, 126)), $urandom_range(0, 2), n, g, ex, ew);
        compared++;
        if (cur_x !== 7'd79 || cur_y !== 6'd59) begin
            mismatched++;
            $display("FAIL wrap_setup got=(%0d,%0d) required=(79,59)", cur_x, cur_y);
        end
        do_key(8'h5A, 3, n, g, ex, ew);
        compared++;
        if (n != 1 || g.x != 79 || g.y != 59 || g.a != 'h5A || g.c != ew.c) begin
            mismatched++;
            $display("FAIL wrap_write n=%0d got=(%0d,%0d,%02h,%0d) required 1 write (79,59,5A,%0d)",
                     n, g.x, g.y, g.a, g.c, ew.c);
        end
        compared++;
        if (g.held != 4 || !g.stable) begin
            mismatched++;
            $display("FAIL wrap_hold held=%0d stable=%0b required held=4 stable=1", g.held, g.stable);
        end
        compared++;
        if (cur_x !== '0 || cur_y !== '0) begin
            mismatched++;
            $display("FAIL wrap_cursor got=(%0d,%0d) required=(0,0)", cur_x, cur_y);
        end
    endtask

    task automatic test_backspace();
        int n; wr_t g, ew; bit ex;
        apply_reset();
        for (int i = 0; i < 5; i++) do_key(8'h0D, 0, n, g, ex, ew);
        do_key(8'h08, 1, n, g, ex, ew);
        compared++;
        if (n != 1 || g.x != 79 || g.y != 4 || g.a != 'h20 || g.c != ew.c) begin
            mismatched++;
            $display("FAIL bs_write n=%0d got=(%0d,%0d,%02h,%0d) required 1 write (79,4,20,%0d)",
                     n, g.x, g.y, g.a, g.c, ew.c);
        end
        compared++;
        if (cur_x !== 7'd79 || cur_y !== 6'd4) begin
            mismatched++;
            $display("FAIL bs_cursor got=(%0d,%0d) required=(79,4)", cur_x, cur_y);
        end
        apply_reset();
        do_key(8'h08, 0, n, g, ex, ew);
        compared++;
        if (n != 0 || cur_x !== '0 || cur_y !== '0) begin
            mismatched++;
            $display("FAIL bs_origin writes=%0d cursor=(%0d,%0d) required 0 writes (0,0)", n, cur_x, cur_y);
        end
    endtask

    task automatic test_newline();
        int n; wr_t g, ew; bit ex;
        apply_reset();
        for (int i = 0; i < 59; i++) do_key(8'h0A, 0, n, g, ex, ew);
        for (int i = 0; i < 17; i++) do_key(8'($urandom_range(32, 126)), 0, n, g, ex, ew);
        do_key(8'h0D, 0, n, g, ex, ew);
        compared++;
        if (n != 0 || cur_x !== '0 || cur_y !== '0) begin
            mismatched++;
            $display("FAIL newline_wrap writes=%0d cursor=(%0d,%0d) required 0 writes (0,0)", n, cur_x, cur_y);
        end
    endtask

    task automatic test_random(input int count, input string tag);
        int n, r; wr_t g, ew; bit ex; logic [7:0] k;
        for (int i = 0; i < count; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      k = 8'($urandom_range(32, 126));
            else if (r < 78) k = 8'h08;
            else if (r < 84) k = 8'h0D;
            else if (r < 90) k = 8'h0A;
            else             k = 8'($urandom_range(127, 255));
            do_key(k, $urandom_range(0, 3), n, g, ex, ew);
            compared++;
            if (n != (ex ? 1 : 0)) begin
                mismatched++;
                $display("FAIL %s_count key=%02h writes=%0d required=%0d", tag, k, n, ex ? 1 : 0);
            end else if (ex) begin
                compared++;
                if (g.x != ew.x || g.y != ew.y || g.a != ew.a || g.c != ew.c || !g.stable) begin
                    mismatched++;
                    $display("FAIL %s_write key=%02h got=(%0d,%0d,%02h,%0d) required=(%0d,%0d,%02h,%0d)",
                             tag, k, g.x, g.y, g.a, g.c, ew.x, ew.y, ew.a, ew.c);
                end
            end
            compared++;
            if (int'(cur_x) != m_x || int'(cur_y) != m_y) begin
                mismatched++;
                $display("FAIL %s_cursor key=%02h got=(%0d,%0d) required=(%0d,%0d)", tag, k, cur_x, cur_y, m_x, m_y);
            end
        end
    endtask

    task automatic test_mode_change();
        int n0, bad_en, bad_rdy, bad_cell;
        bit will_acc;
        wr_t e;
        n0 = wlog.size();
        bad_en = 0; bad_rdy = 0; bad_cell = 0; will_acc = 0;
        ack_delay = 0;
        colour = 3'd7;
        sL = 1;
        key_valid = 1;
        key_ascii = 8'h51;
        for (int i = 0; i < 20000 && wlog.size() < n0 + 1201; i++) begin
            @(negedge clk);
            if (will_acc) key_valid = 0;
            if (busy && (wlog.size() - n0) < 1200) begin
                if (cur_en !== 1'b0) bad_en++;
                if (key_ready !== 1'b0) bad_rdy++;
            end
            will_acc = key_valid && key_ready;
        end
        key_valid = 0;
        wait_idle();
        compared++;
        if (wlog.size() - n0 != 1201) begin
            mismatched++;
            $display("FAIL mode_count writes=%0d required=1201 (1200 clear + 1 key)", wlog.size() - n0);
        end else begin
            for (int i = 0; i < 1200; i++) begin
                e = wlog[n0 + i];
                if (e.x != i % COLS_L || e.y != i / COLS_L || e.a != 'h20 || e.c != 0) bad_cell++;
            end
            compared++;
            if (bad_cell != 0) begin
                mismatched++;
                $display("FAIL mode_cells bad=%0d required=0", bad_cell);
            end
            e = wlog[n0 + 1199];
            compared++;
            if (e.x != 39 || e.y != 29) begin
                mismatched++;
                $display("FAIL mode_last got=(%0d,%0d) required=(39,29)", e.x, e.y);
            end
            e = wlog[n0 + 1200];
            compared++;
            if (e.x != 0 || e.y != 0 || e.a != 'h51 || e.c != 7) begin
                mismatched++;
                $display("FAIL mode_held_key got=(%0d,%0d,%02h,%0d) required=(0,0,51,7)", e.x, e.y, e.a, e.c);
            end
        end
        compared++;
        if (bad_en != 0 || bad_rdy != 0) begin
            mismatched++;
            $display("FAIL mode_flags cur_en_high=%0d key_ready_high=%0d required 0/0", bad_en, bad_rdy);
        end
        compared++;
        if (cur_x !== 7'd1 || cur_y !== 6'd0 || cur_en !== 1'b1) begin
            mismatched++;
            $display("FAIL mode_after cursor=(%0d,%0d) en=%b required=(1,0) en=1", cur_x, cur_y, cur_en);
        end
        m_cols = COLS_L; m_rows = ROWS_L; m_x = 1; m_y = 0;
    endtask

    task automatic test_clear_abort();
        int bad_cell;
        wr_t e;
        apply_reset();
        ack_delay = 0;
        key_valid = 1;
        key_ascii = 8'h1B;
        @(posedge clk);
        @(negedge clk);
        key_valid = 0;
        for (int i = 0; i < 1000 && wlog.size() < 100; i++) @(negedge clk);
        resetn = 0;
        #1;
        compared++;
        if (wr_req !== 1'b0 || busy !== 1'b0 || cur_x !== '0 || cur_y !== '0) begin
            mismatched++;
            $display("FAIL abort_async req=%b busy=%b cursor=(%0d,%0d) required req=0 busy=0 (0,0)",
                     wr_req, busy, cur_x, cur_y);
        end
        @(negedge clk);
        resetn = 1;
        repeat (20) @(negedge clk);
        compared++;
        if (wlog.size() != 100 || wr_req !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_writes total=%0d req=%b required total=100 req=0", wlog.size(), wr_req);
        end else begin
            bad_cell = 0;
            for (int i = 0; i < 100; i++) begin
                e = wlog[i];
                if (e.x != i % COLS_S || e.y != i / COLS_S || e.a != 'h20 || e.c != 0) bad_cell++;
            end
            compared++;
            if (bad_cell != 0) begin
                mismatched++;
                $display("FAIL abort_cells bad=%0d required=0", bad_cell);
            end
        end
        compared++;
        if (key_ready !== 1'b1 || cur_en !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_idle rdy=%b en=%b required 1/1", key_ready, cur_en);
        end
    endtask

    initial begin
        test_reset();
        test_first_key();
        test_wrap();
        test_backspace();
        test_newline();
        apply_reset();
        test_random(250, "rand_small");
        test_mode_change();
        test_random(250, "rand_large");
        test_clear_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
